// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rectangular-to-polar stage and its consumers.
//   AMP_W / PHI_W : amplitude and phase word widths
//   amp_t / phi_t : unsigned amplitude, signed phase (PHI_PI = pi, wraps to -PHI_PI)
//   stats_state_e : handshake state of the phase statistics block
package cordic_pkg;

   localparam int AMP_W  = 12;
   localparam int PHI_W  = 11;
   localparam int PHI_PI = 1024;

   typedef logic        [AMP_W-1:0] amp_t;
   typedef logic signed [PHI_W-1:0] phi_t;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_STALL = 1'b1
   } stats_state_e;

endpackage

// File: rtl/phase_diff.sv
// Wrapped phase increment between consecutive accepted samples.
//   clk_i, rst_i (async, active-low)
//   clear_i  : forget the previous phase; the next sample reports dphi = 0
//   accept_i : a sample is taken this cycle; phi_i becomes the new reference
//   phi_i    : current sample phase
//   dphi_o   : phi_i - previous phase, modulo 2**PHI_W (0 for the first sample)
module phase_diff
   import cordic_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic accept_i,
   input  phi_t phi_i,
   output phi_t dphi_o
);

   phi_t prev_q, prev_d;
   logic first_q, first_d;

   always_comb begin
      prev_d  = prev_q;
      first_d = first_q;
      if (clear_i) begin
         first_d = 1'b1;
      end else if (accept_i) begin
         prev_d  = phi_i;
         first_d = 1'b0;
      end
   end

   // Truncation to PHI_W bits gives the natural +/-pi wrap of the difference.
   always_comb begin
      dphi_o = '0;
      if (!first_q) begin
         dphi_o = phi_t'(phi_i - prev_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         prev_q  <= '0;
         first_q <= 1'b1;
      end else begin
         prev_q  <= prev_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/cordic_phase_stats.sv
// Windowed statistics over the CORDIC amp/phi stream.
// Each window of 2**LOG2_WIN accepted samples yields mean amplitude, peak
// amplitude and mean wrapped phase increment (a frequency estimate).
//   clk_i, rst_i (async, active-low), clear_i (sync window restart)
//   amp_i, phi_i, valid_i / ready_o       : sample input handshake
//   amp_avg_o, amp_max_o, dphi_avg_o      : window results
//   valid_o / ready_i                     : result output handshake
module cordic_phase_stats
   import cordic_pkg::*;
#(
   parameter int LOG2_WIN = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  amp_t amp_i,
   input  phi_t phi_i,
   input  logic valid_i,
   output logic ready_o,
   output amp_t amp_avg_o,
   output amp_t amp_max_o,
   output phi_t dphi_avg_o,
   output logic valid_o,
   input  logic ready_i
);

   localparam int SUM_AW = AMP_W + LOG2_WIN;
   localparam int SUM_PW = PHI_W + LOG2_WIN;
   localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

   function automatic amp_t amp_floor_avg(input logic [SUM_AW-1:0] s);
      return s[SUM_AW-1:LOG2_WIN];
   endfunction

   function automatic phi_t dphi_floor_avg(input logic signed [SUM_PW-1:0] s);
      return phi_t'(s >>> LOG2_WIN);
   endfunction

   logic accept;
   phi_t dphi;

   logic        [LOG2_WIN-1:0] cnt_q, cnt_d;
   logic        [SUM_AW-1:0]   amp_sum_q, amp_sum_d, amp_sum_nx;
   logic signed [SUM_PW-1:0]   dphi_sum_q, dphi_sum_d, dphi_sum_nx;
   amp_t                       amp_max_q, amp_max_d, amp_max_nx;
   amp_t                       amp_avg_q, amp_avg_d;
   amp_t                       amp_pk_q, amp_pk_d;
   phi_t                       dphi_avg_q, dphi_avg_d;
   logic                       valid_q, valid_d;
   stats_state_e               state_q, state_d;

   // STALL means the window's final sample is waiting on a pending result,
   // so ready_o never depends on ready_i.
   assign ready_o = rst_i & ~clear_i & (state_q == ST_ACCUM);
   assign accept  = valid_i & ready_o;

   phase_diff u_phase_diff (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .accept_i (accept),
      .phi_i    (phi_i),
      .dphi_o   (dphi)
   );

   // A sample at cnt==0 starts a new window, so it loads instead of adding.
   always_comb begin
      amp_sum_nx  = {{LOG2_WIN{1'b0}}, amp_i};
      dphi_sum_nx = $signed({{LOG2_WIN{dphi[PHI_W-1]}}, dphi});
      amp_max_nx  = amp_i;
      if (cnt_q != '0) begin
         amp_sum_nx  = amp_sum_q + amp_sum_nx;
         dphi_sum_nx = dphi_sum_q + dphi_sum_nx;
         if (amp_max_q > amp_i) begin
            amp_max_nx = amp_max_q;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      amp_sum_d  = amp_sum_q;
      dphi_sum_d = dphi_sum_q;
      amp_max_d  = amp_max_q;
      amp_avg_d  = amp_avg_q;
      amp_pk_d   = amp_pk_q;
      dphi_avg_d = dphi_avg_q;
      valid_d    = valid_q;

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      if (clear_i) begin
         cnt_d      = '0;
         amp_sum_d  = '0;
         dphi_sum_d = '0;
         amp_max_d  = '0;
      end else if (accept) begin
         cnt_d      = cnt_q + LOG2_WIN'(1);
         amp_sum_d  = amp_sum_nx;
         dphi_sum_d = dphi_sum_nx;
         amp_max_d  = amp_max_nx;
         if (cnt_q == CNT_LAST) begin
            amp_avg_d  = amp_floor_avg(amp_sum_nx);
            amp_pk_d   = amp_max_nx;
            dphi_avg_d = dphi_floor_avg(dphi_sum_nx);
            valid_d    = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = ST_ACCUM;
      if ((cnt_d == CNT_LAST) && valid_d) begin
         state_d = ST_STALL;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q      <= '0;
         amp_sum_q  <= '0;
         dphi_sum_q <= '0;
         amp_max_q  <= '0;
         amp_avg_q  <= '0;
         amp_pk_q   <= '0;
         dphi_avg_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         amp_sum_q  <= amp_sum_d;
         dphi_sum_q <= dphi_sum_d;
         amp_max_q  <= amp_max_d;
         amp_avg_q  <= amp_avg_d;
         amp_pk_q   <= amp_pk_d;
         dphi_avg_q <= dphi_avg_d;
         valid_q    <= valid_d;
      end
   end

   assign amp_avg_o  = amp_avg_q;
   assign amp_max_o  = amp_pk_q;
   assign dphi_avg_o = dphi_avg_q;
   assign valid_o    = valid_q;

endmodule

// File: tb/tb_cordic_phase_stats.sv
module tb_cordic_phase_stats;
   import cordic_pkg::*;

   localparam int L = 2;
   localparam int N = 1 << L;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic clear_i = 1'b0;
   amp_t amp_i = '0;
   phi_t phi_i = '0;
   logic valid_i = 1'b0;
   logic ready_o;
   amp_t amp_avg_o;
   amp_t amp_max_o;
   phi_t dphi_avg_o;
   logic valid_o;
   logic ready_i = 1'b1;

   cordic_phase_stats #(.LOG2_WIN(L)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .amp_i      (amp_i),
      .phi_i      (phi_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .amp_avg_o  (amp_avg_o),
      .amp_max_o  (amp_max_o),
      .dphi_avg_o (dphi_avg_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int amp_avg;
      int amp_max;
      int dphi_avg;
   } res_t;

   res_t exp_q[$];
   int   win_amp[$];
   int   win_dphi[$];
   bit   m_first = 1'b1;
   int   m_prev = 0;

   int errors = 0;
   int checks = 0;
   bit rand_rdy = 1'b0;
   int last_waits = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: phase difference folded into [-pi, pi), floor division.
   function automatic int wrap_phase(input int v);
      int r;
      r = v % (2 * PHI_PI);
      if (r < 0) r += 2 * PHI_PI;
      if (r >= PHI_PI) r -= 2 * PHI_PI;
      return r;
   endfunction

   function automatic int floor_div(input int s, input int n);
      if (s >= 0) return s / n;
      return -((-s + n - 1) / n);
   endfunction

   task automatic model_accept(input int a, input int p);
      int d;
      res_t r;
      int sa, sd, mx;
      d = m_first ? 0 : wrap_phase(p - m_prev);
      m_first = 1'b0;
      m_prev = p;
      win_amp.push_back(a);
      win_dphi.push_back(d);
      if (win_amp.size() == N) begin
         sa = 0; sd = 0; mx = 0;
         foreach (win_amp[i]) begin
            sa += win_amp[i];
            sd += win_dphi[i];
            if (win_amp[i] > mx) mx = win_amp[i];
         end
         r.amp_avg  = sa / N;
         r.amp_max  = mx;
         r.dphi_avg = floor_div(sd, N);
         exp_q.push_back(r);
         win_amp.delete();
         win_dphi.delete();
      end
   endtask

   task automatic model_clear();
      win_amp.delete();
      win_dphi.delete();
      m_first = 1'b1;
   endtask

   // Monitor: inputs change just after posedge, so at negedge valid_o & ready_i
   // predicts a transfer on the coming edge.
   bit   stalled = 1'b0;
   res_t held;

   always @(negedge clk) begin
      if (!rst_i) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_valid", int'(valid_o), 1);
            chk("hold_amp_avg", int'(amp_avg_o), held.amp_avg);
            chk("hold_amp_max", int'(amp_max_o), held.amp_max);
            chk("hold_dphi_avg", int'(dphi_avg_o), held.dphi_avg);
         end
         if (valid_o && ready_i) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("amp_avg", int'(amp_avg_o), e.amp_avg);
               chk("amp_max", int'(amp_max_o), e.amp_max);
               chk("dphi_avg", int'(dphi_avg_o), e.dphi_avg);
            end
         end else if (valid_o) begin
            stalled = 1'b1;
            held.amp_avg  = int'(amp_avg_o);
            held.amp_max  = int'(amp_max_o);
            held.dphi_avg = int'(dphi_avg_o);
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send(input int a, input int p);
      bit done;
      done = 1'b0;
      last_waits = 0;
      amp_i = AMP_W'(a);
      phi_i = PHI_W'(p);
      valid_i = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (ready_o) begin
            model_accept(a, p);
            done = 1'b1;
         end else begin
            last_waits++;
            if (last_waits > 40) begin
               chk("send_timeout", 0, 1);
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
         if (!done && rand_rdy) ready_i = 1'($urandom_range(0, 1));
      end
      valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      valid_i = 1'b0;
      clear_i = 1'b0;
      model_clear();
      exp_q.delete();
      @(negedge clk);
      chk("rst_amp_avg", int'(amp_avg_o), 0);
      chk("rst_amp_max", int'(amp_max_o), 0);
      chk("rst_dphi_avg", int'(dphi_avg_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_ready", int'(ready_o), 0);
      @(posedge clk); #1;
      rst_i = 1'b1;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      valid_i = 1'b1;
      amp_i = 12'd777;
      @(negedge clk);
      chk("clear_ready", int'(ready_o), 0);
      @(posedge clk); #1;
      clear_i = 1'b0;
      valid_i = 1'b0;
      model_clear();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      do_reset();

      // 1: constant window, result one cycle after the last sample
      for (int i = 0; i < N; i++) send(1000, 100);
      @(negedge clk);
      chk("latency_valid", int'(valid_o), 1);
      @(posedge clk); #1;

      // 2: ramp after a restart, then a second window
      do_clear();
      for (int i = 0; i < 8; i++) send(500 + i, i * 100);

      // 3: phase wrap through +/-pi
      for (int i = 0; i < 4; i++) send(300, 500 + i * 100);
      send(300, 900); send(300, 1000); send(300, -1000); send(300, -900);

      // 4: full-scale amplitudes
      send(4095, 0); send(0, 0); send(1, 0); send(2, 0);
      idle(2);

      // 5: backpressure stalls only the final sample of the second window
      ready_i = 1'b0;
      for (int i = 0; i < 7; i++) send(100 * i, 50 * i);
      amp_i = 12'd900;
      phi_i = 11'sd400;
      valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_ready", int'(ready_o), 0);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      @(negedge clk);
      chk("ready_registered", int'(ready_o), 0);
      @(posedge clk); #1;
      send(900, 400);
      chk("accept_after_release", last_waits, 0);
      @(negedge clk);
      chk("result2_valid", int'(valid_o), 1);
      @(posedge clk); #1;

      // 6: reset mid-window, then a fresh window
      send(1, 5); send(2, 6);
      do_reset();
      send(10, 10); send(10, 20); send(10, 30); send(10, 40);
      idle(2);

      // 7: clear with a result pending
      ready_i = 1'b0;
      for (int i = 0; i < N; i++) send(200 + i, 30 * i);
      for (int i = 0; i < 3; i++) send(50, -100 * i);
      do_clear();
      @(negedge clk);
      chk("clear_keeps_pending", int'(valid_o), 1);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) send(600 + i, 700 + 200 * i);
      ready_i = 1'b1;
      send(611, -1020);
      idle(3);

      // Randomized traffic with random backpressure and occasional clears
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) do_clear();
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
         send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)) - 1024);
      end
      rand_rdy = 1'b0;
      ready_i = 1'b1;
      idle(10);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
